// File: rtl/memory_access_pkg.sv
// Shared types and constants for the load/store bus controller and data alignment.
// No logic; imported by the controller, its interface users and the aligner.
package memory_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SEL_B0 = 4'b0001;
    localparam logic [3:0] SEL_B1 = 4'b0010;
    localparam logic [3:0] SEL_B2 = 4'b0100;
    localparam logic [3:0] SEL_B3 = 4'b1000;
    localparam logic [3:0] SEL_H0 = 4'b0011;
    localparam logic [3:0] SEL_H1 = 4'b1100;
    localparam logic [3:0] SEL_W  = 4'b1111;

    localparam int TIMEOUT_CNT_W = 8;

endpackage

// File: rtl/memory_access_controller_if.sv
// Core request/response and Wishbone-style bus signals of the load/store controller.
// The slave modport is the controller's view; master is the pipeline/bus side.
interface memory_access_controller_if;
    logic        coreMemoryEnable;
    logic        coreMemoryWriteEnable;
    logic [3:0]  coreByteSelect;
    logic [31:0] coreAddress;
    logic [31:0] coreWriteData;
    logic        coreLoadSigned;
    logic [31:0] coreReadData;
    logic        coreBusy;
    logic        coreDone;
    logic        coreBusError;
    logic        wbCyc;
    logic        wbStb;
    logic        wbWe;
    logic [3:0]  wbSel;
    logic [31:0] wbAdr;
    logic [31:0] wbDatOut;
    logic        wbAck;
    logic        wbErr;
    logic [31:0] wbDatIn;

    modport slave (
        input  coreMemoryEnable, coreMemoryWriteEnable, coreByteSelect, coreAddress,
               coreWriteData, coreLoadSigned, wbAck, wbErr, wbDatIn,
        output coreReadData, coreBusy, coreDone, coreBusError,
               wbCyc, wbStb, wbWe, wbSel, wbAdr, wbDatOut
    );

    modport master (
        output coreMemoryEnable, coreMemoryWriteEnable, coreByteSelect, coreAddress,
               coreWriteData, coreLoadSigned, wbAck, wbErr, wbDatIn,
        input  coreReadData, coreBusy, coreDone, coreBusError,
               wbCyc, wbStb, wbWe, wbSel, wbAdr, wbDatOut
    );
endinterface

// File: rtl/load_data_aligner.sv
// Right-aligns lane-positioned load data by byte select and sign/zero extends it.
// Purely combinational, no handshake; non-contiguous selects pass the word through.
module load_data_aligner
    import memory_access_pkg::*;
(
    input  logic [3:0]  sel,
    input  logic        load_signed,
    input  logic [31:0] raw,
    output logic [31:0] aligned
);

    logic [1:0]  low_lane;
    logic [2:0]  pop;
    logic        contig;
    logic [31:0] shifted;

    always_comb begin
        low_lane = 2'd0;
        if (sel[0])      low_lane = 2'd0;
        else if (sel[1]) low_lane = 2'd1;
        else if (sel[2]) low_lane = 2'd2;
        else if (sel[3]) low_lane = 2'd3;

        pop = {2'b00, sel[0]} + {2'b00, sel[1]} + {2'b00, sel[2]} + {2'b00, sel[3]};

        case (sel)
            SEL_B0, SEL_B1, SEL_B2, SEL_B3,
            SEL_H0, 4'b0110, SEL_H1,
            4'b0111, 4'b1110, SEL_W: contig = 1'b1;
            default:                 contig = 1'b0;
        endcase

        shifted = contig ? (raw >> {low_lane, 3'b000}) : raw;

        if (contig && pop == 3'd1)
            aligned = {{24{load_signed & shifted[7]}}, shifted[7:0]};
        else if (contig && pop == 3'd2)
            aligned = {{16{load_signed & shifted[15]}}, shifted[15:0]};
        else
            aligned = shifted;
    end

endmodule

// File: rtl/memory_access_controller.sv
// Runs one Wishbone-style bus cycle per accepted load/store; done 2+ cycles after request.
// Pipe stalls on coreBusy; optional bus timeout under `ifdef MEMORY_TIMEOUT_EN.
module memory_access_controller
    import memory_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic                        clk,
    input  logic                        rst,
    memory_access_controller_if.slave   mif
);

    state_t      state;
    logic        ld_signed_q;
    logic        accept;
    logic        timeout;
    logic [31:0] load_aligned;

    assign accept = mif.coreMemoryEnable && (mif.coreByteSelect != 4'b0000);

    always_comb begin
        mif.coreBusy = ((state == IDLE) && accept) || (state == BUS);
    end

`ifdef MEMORY_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0] tmo_cnt;
    assign timeout = (tmo_cnt == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state == IDLE)
            tmo_cnt <= '0;
        else if (state == BUS && !mif.wbAck && !mif.wbErr)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    load_data_aligner u_aligner (
        .sel         (mif.wbSel),
        .load_signed (ld_signed_q),
        .raw         (mif.wbDatIn),
        .aligned     (load_aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            ld_signed_q      <= 1'b0;
            mif.wbCyc        <= 1'b0;
            mif.wbStb        <= 1'b0;
            mif.wbWe         <= 1'b0;
            mif.wbSel        <= 4'b0000;
            mif.wbAdr        <= 32'h0;
            mif.wbDatOut     <= 32'h0;
            mif.coreReadData <= 32'h0;
            mif.coreDone     <= 1'b0;
            mif.coreBusError <= 1'b0;
        end else begin
            mif.coreDone     <= 1'b0;
            mif.coreBusError <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mif.wbCyc    <= 1'b1;
                        mif.wbStb    <= 1'b1;
                        mif.wbWe     <= mif.coreMemoryWriteEnable;
                        mif.wbSel    <= mif.coreByteSelect;
                        mif.wbAdr    <= {mif.coreAddress[31:2], 2'b00};
                        mif.wbDatOut <= mif.coreWriteData;
                        ld_signed_q  <= mif.coreLoadSigned;
                        state        <= BUS;
                    end
                end
                BUS: begin
                    // Error outranks ack so a simultaneous err/ack still reports failure.
                    if (mif.wbErr || (timeout && !mif.wbAck)) begin
                        mif.coreBusError <= 1'b1;
                        mif.coreDone     <= 1'b1;
                        mif.coreReadData <= 32'h0;
                        mif.wbCyc        <= 1'b0;
                        mif.wbStb        <= 1'b0;
                        state            <= DONE;
                    end else if (mif.wbAck) begin
                        mif.coreDone     <= 1'b1;
                        mif.coreReadData <= mif.wbWe ? 32'h0 : load_aligned;
                        mif.wbCyc        <= 1'b0;
                        mif.wbStb        <= 1'b0;
                        state            <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_controller.sv
// Scoreboarded bench for memory_access_controller; covers the MEMORY_TIMEOUT_EN build too.
module tb_memory_access_controller;
    import memory_access_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_access_controller_if mif();

    memory_access_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                             input logic [31:0] wd, input logic sgn);
        mif.coreMemoryEnable      = 1'b1;
        mif.coreMemoryWriteEnable = we;
        mif.coreByteSelect        = sel;
        mif.coreAddress           = adr;
        mif.coreWriteData         = wd;
        mif.coreLoadSigned        = sgn;
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        chk({tag, ".done"}, {31'b0, mif.coreDone}, 32'd1);
        chk({tag, ".busy_in_done"}, {31'b0, mif.coreBusy}, 32'd0);
        chk({tag, ".stb_drop"}, {30'b0, mif.wbCyc, mif.wbStb}, 32'd0);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (mif.coreDone) begin
                chk({tag, ".rdata"}, mif.coreReadData, e.rd);
                chk({tag, ".err"}, {31'b0, mif.coreBusError}, {31'b0, e.err});
            end
        end
    endtask

    task automatic access(input string tag, input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] wd, input logic sgn,
                          input logic [31:0] raw, input int waits, input logic err,
                          input logic [31:0] exp_rd);
        exp_t e;
        e.rd  = exp_rd;
        e.err = err;
        sb.push_back(e);
        @(negedge clk);
        drive_req(we, sel, adr, wd, sgn);
        #1 chk({tag, ".busy_c0"}, {31'b0, mif.coreBusy}, 32'd1);
        @(negedge clk);
        chk({tag, ".cyc_stb"}, {30'b0, mif.wbCyc, mif.wbStb}, 32'd3);
        chk({tag, ".we"}, {31'b0, mif.wbWe}, {31'b0, we});
        chk({tag, ".sel"}, {28'b0, mif.wbSel}, {28'b0, sel});
        chk({tag, ".adr"}, mif.wbAdr, {adr[31:2], 2'b00});
        chk({tag, ".busy_c1"}, {31'b0, mif.coreBusy}, 32'd1);
        if (we) chk({tag, ".wdat"}, mif.wbDatOut, wd);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk({tag, ".held"}, {26'b0, mif.wbCyc, mif.wbStb, mif.wbSel}, {26'b0, 2'b11, sel});
        end
        mif.wbAck   = ~err;
        mif.wbErr   = err;
        mif.wbDatIn = raw;
        @(negedge clk);
        check_done(tag);
        mif.wbAck            = 1'b0;
        mif.wbErr            = 1'b0;
        mif.coreMemoryEnable = 1'b0;
        @(negedge clk);
        chk({tag, ".done_pulse"}, {30'b0, mif.coreDone, mif.coreBusError}, 32'd0);
    endtask

    initial begin
        mif.coreMemoryEnable      = 1'b0;
        mif.coreMemoryWriteEnable = 1'b0;
        mif.coreByteSelect        = 4'b0;
        mif.coreAddress           = 32'h0;
        mif.coreWriteData         = 32'h0;
        mif.coreLoadSigned        = 1'b0;
        mif.wbAck                 = 1'b0;
        mif.wbErr                 = 1'b0;
        mif.wbDatIn               = 32'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.bus", {26'b0, mif.wbCyc, mif.wbStb, mif.wbWe, mif.wbSel[2:0]}, 32'd0);
        chk("rst.adr", mif.wbAdr | mif.wbDatOut, 32'h0);
        chk("rst.core", {29'b0, mif.coreDone, mif.coreBusError, mif.coreBusy}, 32'd0);
        chk("rst.rdata", mif.coreReadData, 32'h0);
        rst = 1'b0;

        // Zero byte-select request must be ignored entirely.
        @(negedge clk);
        drive_req(1'b0, 4'b0000, 32'h2000, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("sel0.quiet", {29'b0, mif.coreBusy, mif.wbStb, mif.coreDone}, 32'd0);
            @(negedge clk);
        end
        mif.coreMemoryEnable = 1'b0;

        access("word",   1'b0, SEL_W,   32'h0000_1000, 32'h0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF);
        access("sbyte",  1'b0, SEL_B2,  32'h0000_1003, 32'h0, 1'b1, 32'h0080_0000, 0, 1'b0, 32'hFFFF_FF80);
        access("ubyte",  1'b0, SEL_B2,  32'h0000_1002, 32'h0, 1'b0, 32'h0080_0000, 1, 1'b0, 32'h0000_0080);
        access("shalf",  1'b0, SEL_H1,  32'h0000_2000, 32'h0, 1'b1, 32'h8001_ABCD, 0, 1'b0, 32'hFFFF_8001);
        access("uhalf",  1'b0, SEL_H0,  32'h0000_2004, 32'h0, 1'b0, 32'h1234_ABCD, 0, 1'b0, 32'h0000_ABCD);
        access("midhalf",1'b0, 4'b0110, 32'h0000_2008, 32'h0, 1'b1, 32'h00F0_0000, 0, 1'b0, 32'hFFFF_F000);
        access("b3",     1'b0, SEL_B3,  32'h0000_200C, 32'h0, 1'b1, 32'h7F00_0000, 0, 1'b0, 32'h0000_007F);
        access("tri",    1'b0, 4'b1110, 32'h0000_2010, 32'h0, 1'b1, 32'hAABB_CCDD, 0, 1'b0, 32'h00AA_BBCC);
        access("noncon", 1'b0, 4'b0101, 32'h0000_2014, 32'h0, 1'b1, 32'h1234_5678, 0, 1'b0, 32'h1234_5678);
        access("store",  1'b1, SEL_H0,  32'h0000_3000, 32'h0000_1234, 1'b0, 32'hFFFF_FFFF, 5, 1'b0, 32'h0);

        // Err with ack together: error wins.
        sb.push_back('{rd: 32'h0, err: 1'b1});
        @(negedge clk);
        drive_req(1'b0, SEL_W, 32'h0000_4000, 32'h0, 1'b0);
        @(negedge clk);
        mif.wbAck = 1'b1; mif.wbErr = 1'b1; mif.wbDatIn = 32'hCAFE_F00D;
        @(negedge clk);
        check_done("errack");
        mif.wbAck = 1'b0; mif.wbErr = 1'b0; mif.coreMemoryEnable = 1'b0;
        @(negedge clk);

        // No response from the bus.
        @(negedge clk);
        drive_req(1'b0, SEL_W, 32'h0000_5000, 32'h0, 1'b0);
`ifdef MEMORY_TIMEOUT_EN
        begin
            int n = 0;
            sb.push_back('{rd: 32'h0, err: 1'b1});
            while (!mif.coreDone && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("tmo.latency", n, 32'd5);
            check_done("tmo");
            mif.coreMemoryEnable = 1'b0;
            @(negedge clk);
        end
`else
        begin
            int seen = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (mif.coreDone) seen++;
            end
            chk("hang.busy", {30'b0, mif.coreBusy, mif.wbStb}, 32'd3);
            chk("hang.nodone", seen, 32'd0);
            sb.push_back('{rd: 32'h5555_AAAA, err: 1'b0});
            mif.wbAck = 1'b1; mif.wbDatIn = 32'h5555_AAAA;
            @(negedge clk);
            check_done("hang_end");
            mif.wbAck = 1'b0; mif.coreMemoryEnable = 1'b0;
            @(negedge clk);
        end
`endif

        // Reset in the middle of a bus cycle abandons it.
        @(negedge clk);
        drive_req(1'b0, SEL_W, 32'h0000_6000, 32'h0, 1'b0);
        @(negedge clk);
        chk("rstmid.pre", {31'b0, mif.wbStb}, 32'd1);
        rst = 1'b1;
        #1 chk("rstmid.drop", {29'b0, mif.wbCyc, mif.wbStb, mif.coreDone}, 32'd0);
        @(negedge clk);
        mif.coreMemoryEnable = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid.nodone", {31'b0, mif.coreDone}, 32'd0);
        access("post_rst", 1'b0, SEL_B1, 32'h0000_7000, 32'h0, 1'b1, 32'h0000_8100, 0, 1'b0, 32'hFFFF_FF81);

        chk("sb.drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access_controller.md
Name: memory_access_controller

Overview:
Responder side of the execute stage's load/store request interface. It accepts the word-aligned request (enable, write enable, byte select, address, lane-positioned write data) and runs one Wishbone-style bus cycle. It returns right-aligned, optionally sign-extended load data plus busy/done/error status, which drive the pipe stall. It sits between the core pipeline and the core's data bus master port.

Parameters:
TIMEOUT_CYCLES, 255, number of BUS-state cycles without ack/err before a bus error is flagged. 8-bit counter; legal range 1..255. Only used when MEMORY_TIMEOUT_EN is defined.

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
coreMemoryEnable  input  1  request valid; held by requester until coreDone
coreMemoryWriteEnable  input  1  1 = store, 0 = load
coreByteSelect  input  4  active byte lanes
coreAddress  input  32  word-aligned address; bits[1:0] are ignored
coreWriteData  input  32  store data, already positioned in lanes
coreLoadSigned  input  1  sign-extend byte/half loads
coreReadData  output  32  aligned load result; valid while coreDone=1
coreBusy  output  1  request outstanding, pipe must stall
coreDone  output  1  one-cycle completion pulse
coreBusError  output  1  one-cycle error pulse, coincident with coreDone
wbCyc  output  1  bus cycle
wbStb  output  1  bus strobe
wbWe  output  1  bus write
wbSel  output  4  bus byte select
wbAdr  output  32  bus address, {coreAddress[31:2],2'b00}
wbDatOut  output  32  bus write data
wbAck  input  1  bus acknowledge
wbErr  input  1  bus error
wbDatIn  input  32  bus read data

Behaviour:
- Reset (async): state IDLE; wbCyc/wbStb/wbWe=0; wbSel=0; wbAdr/wbDatOut=0; coreReadData=0; coreDone=0; coreBusError=0; timeout counter=0. If reset lands mid-transaction, wbCyc/wbStb drop immediately and the request is abandoned.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - A request is accepted when coreMemoryEnable=1 and coreByteSelect!=0.
  - On accept: latch we/sel/addr/data/signed, set wbCyc=wbStb=1 (registered), go to BUS.
  - A request with sel=0 is ignored: no bus cycle, no done pulse.
- BUS: wbCyc/wbStb remain held. Priority is wbErr > wbAck > timeout.
  - wbErr → coreBusError=1, coreReadData=0, go to DONE.
  - wbAck → capture aligned read data (0 for stores), go to DONE.
  - On leaving BUS, wbCyc/wbStb deassert on the same edge.
- DONE: coreDone=1 for exactly this cycle, then return to IDLE unconditionally. The requester steps on coreDone; a request present in DONE is not accepted until the following IDLE cycle.
- coreBusy (combinational) = (IDLE && accepted request) || BUS. It is 0 in DONE.
- Latency: request seen at cycle 0 → wbStb high in cycle 1 → ack in cycle 1 → coreDone in cycle 2. Minimum 2 cycles; back-to-back throughput is 1 access per 3 cycles.
- Load alignment: shift right by 8× the index of the lowest set bit of the latched sel.
  - Width by popcount: 1 = byte, 2 = half, otherwise word.
  - coreLoadSigned: sign-extend from bit 7 (byte) or bit 15 (half); otherwise zero-extend.
  - Non-contiguous sel patterns are treated as word, unshifted.
- Stores: wbDatOut = latched data unchanged; coreReadData=0 on done.

Optional Feature:
MEMORY_TIMEOUT_EN
- Defined: an 8-bit counter clears on BUS entry and increments each BUS cycle without ack/err. When it reaches TIMEOUT_CYCLES-1 without ack/err, the block behaves as for wbErr.
- Undefined: no counter; BUS waits indefinitely for ack/err.

Decomposition:
- Package memory_access_pkg: FSM state enum (IDLE=0, BUS=1, DONE=2), lane select constants (SEL_B0..SEL_B3, SEL_H0, SEL_H1, SEL_W), timeout counter width (8).
- One combinational sub-module, load_data_aligner (inputs sel, signed, raw data; output aligned data), reused later by the instruction fetch path.

Test Plan:
- Word load addr 0x1000, sel 1111, ack next cycle with wbDatIn 0xDEADBEEF → coreDone at cycle 2, coreReadData 0xDEADBEEF, coreBusy high in cycles 0-1.
- Signed byte load sel 0100, wbDatIn 0x00800000 → 0xFFFFFF80; same with unsigned → 0x00000080; half sel 1100, data 0x8001xxxx, signed → 0xFFFF8001.
- Store sel 0011, data 0x00001234, ack after 5 wait cycles → wbWe=1, wbSel=0011 held stable 6 cycles, coreDone pulse, coreReadData=0.
- wbErr and wbAck asserted together → coreBusError=1 and coreDone=1 same cycle, coreReadData=0.
- MEMORY_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → error done pulse 5 cycles after accept; with macro undefined → still busy after 300 cycles.
- Assert rst while in BUS → wbCyc/wbStb low same cycle, no coreDone; after release, a new request completes normally.
